// File: rtl/clockhand_plotter.sv
// Clock-hand plotter: clears the 64x64 framebuffer, then draws the hour, minute,
// second and (optional) alarm hands as radial lines using an external sin/cos unit.
module clockhand_plotter #(
  parameter int HOUR_LEN  = 22,
  parameter int MIN_LEN   = 31,
  parameter int SEC_LEN   = 27,
  parameter int ALARM_LEN = 17,
  parameter int CENTER    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  hour_angle,
  input  logic [8:0]  minute_angle,
  input  logic [8:0]  second_angle,
  input  logic [8:0]  alarm_angle,
  input  logic        alarm_en,
  output logic        cordic_start,
  output logic [15:0] cordic_angle,
  input  logic [15:0] cordic_sin,
  input  logic [15:0] cordic_cos,
  input  logic        cordic_done,
  output logic        clr_en,
  output logic [5:0]  clr_row,
  output logic        wr_en,
  output logic [5:0]  wr_x,
  output logic [5:0]  wr_y,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, CLEAR, REQ, WAIT, PLOT, NEXT, FIN} state_t;

  localparam logic signed [7:0] CTR = 8'(CENTER);
  localparam logic [1:0] H_SEC   = 2'd2;
  localparam logic [1:0] H_ALARM = 2'd3;

  state_t          state_q, state_d;
  logic [3:0][8:0] ang_q;
  logic            alarm_en_q;
  logic [1:0]      hand_q, hand_d;
  logic [5:0]      r_q, r_d, row_d, len_cur;
  logic [15:0]     sin_q, sin_d, cos_q, cos_d;
  logic            cordic_start_d, clr_en_d, wr_en_d, busy_d, done_d;
  logic [15:0]     cordic_angle_d;
  logic [5:0]      wr_x_d, wr_y_d;
  logic [15:0]     pix_sin, pix_cos;
  logic [5:0]      pix_r;

  // One axis of a pixel: centre +/- round(trig*r / 2^14), clamped to the screen.
  function automatic logic [5:0] axis(input logic [15:0] trig, input logic [5:0] r,
                                      input logic neg);
    logic signed [21:0] prod;
    logic signed [7:0]  off, pos;
    prod = $signed({{6{trig[15]}}, trig}) * $signed({16'd0, r});
    prod = prod + 22'sd8192;
    off  = prod[21:14];
    pos  = neg ? CTR - off : CTR + off;
    if (pos[7])        return 6'd0;
    if (pos > 8'sd63)  return 6'd63;
    return pos[5:0];
  endfunction

  always_comb begin
    case (hand_q)
      2'd0:    len_cur = 6'(HOUR_LEN);
      2'd1:    len_cur = 6'(MIN_LEN);
      2'd2:    len_cur = 6'(SEC_LEN);
      default: len_cur = 6'(ALARM_LEN);
    endcase
  end

  always_comb begin
    state_d        = state_q;
    hand_d         = hand_q;
    r_d            = r_q;
    row_d          = clr_row;
    sin_d          = sin_q;
    cos_d          = cos_q;
    cordic_start_d = 1'b0;
    cordic_angle_d = cordic_angle;
    clr_en_d       = 1'b0;
    wr_en_d        = 1'b0;
    pix_sin        = sin_q;
    pix_cos        = cos_q;
    pix_r          = r_q + 6'd1;
    case (state_q)
      IDLE: if (start) begin
        state_d  = CLEAR;
        row_d    = 6'd0;
        clr_en_d = 1'b1;
      end
      CLEAR: if (clr_row == 6'd63) begin
        state_d        = REQ;
        hand_d         = 2'd0;
        cordic_start_d = 1'b1;
        cordic_angle_d = {7'd0, ang_q[0]};
      end else begin
        row_d    = clr_row + 6'd1;
        clr_en_d = 1'b1;
      end
      REQ: state_d = WAIT;
      // First pixel is formed straight from the incoming result so the write
      // register holds r=1 on the first PLOT cycle.
      WAIT: if (cordic_done) begin
        sin_d   = cordic_sin;
        cos_d   = cordic_cos;
        r_d     = 6'd1;
        state_d = PLOT;
        wr_en_d = 1'b1;
        pix_sin = cordic_sin;
        pix_cos = cordic_cos;
        pix_r   = 6'd1;
      end
      PLOT: if (r_q == len_cur) begin
        state_d = NEXT;
      end else begin
        r_d     = r_q + 6'd1;
        wr_en_d = 1'b1;
      end
      NEXT: if (hand_q == H_ALARM || (hand_q == H_SEC && !alarm_en_q)) begin
        state_d = FIN;
      end else begin
        hand_d         = hand_q + 2'd1;
        state_d        = REQ;
        cordic_start_d = 1'b1;
        cordic_angle_d = {7'd0, ang_q[hand_d]};
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = !(state_d inside {IDLE, FIN});
    done_d = (state_d == FIN);
  end

  always_comb begin
    wr_x_d = wr_x;
    wr_y_d = wr_y;
    if (wr_en_d) begin
      wr_x_d = axis(pix_sin, pix_r, 1'b0);
      wr_y_d = axis(pix_cos, pix_r, 1'b1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ang_q        <= '0;
      alarm_en_q   <= 1'b0;
      hand_q       <= 2'd0;
      r_q          <= 6'd0;
      sin_q        <= 16'd0;
      cos_q        <= 16'd0;
      cordic_start <= 1'b0;
      cordic_angle <= 16'd0;
      clr_en       <= 1'b0;
      clr_row      <= 6'd0;
      wr_en        <= 1'b0;
      wr_x         <= 6'd0;
      wr_y         <= 6'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      hand_q       <= hand_d;
      r_q          <= r_d;
      sin_q        <= sin_d;
      cos_q        <= cos_d;
      cordic_start <= cordic_start_d;
      cordic_angle <= cordic_angle_d;
      clr_en       <= clr_en_d;
      clr_row      <= row_d;
      wr_en        <= wr_en_d;
      wr_x         <= wr_x_d;
      wr_y         <= wr_y_d;
      busy         <= busy_d;
      done         <= done_d;
      if (state_q == IDLE && start) begin
        ang_q      <= {alarm_angle, second_angle, minute_angle, hour_angle};
        alarm_en_q <= alarm_en;
      end
    end
  end
endmodule

// File: tb/tb_clockhand_plotter.sv
// Bench for clockhand_plotter: a sin/cos responder plus a per-frame model built
// from latched angles, returned trig values and hand lengths.
module tb_clockhand_plotter;
  localparam int HL = 22, ML = 31, SL = 27, AL = 17;

  logic        clk = 1'b0;
  logic        reset, start, alarm_en;
  logic [8:0]  hour_angle, minute_angle, second_angle, alarm_angle;
  logic        cordic_start, cordic_done;
  logic [15:0] cordic_angle, cordic_sin, cordic_cos;
  logic        clr_en, wr_en, busy, done;
  logic [5:0]  clr_row, wr_x, wr_y;

  int errors = 0, checks = 0;

  // responder configuration and record of what it returned
  int lat = 1;
  bit rnd_cs = 0, spurious = 0;
  int rsp_sin[$], rsp_cos[$], rsp_lat[$];
  // observed activity
  int mon_clr[$], mon_wx[$], mon_wy[$], mon_req[$];
  int mon_done = 0;

  clockhand_plotter dut (
    .clk(clk), .reset(reset), .start(start),
    .hour_angle(hour_angle), .minute_angle(minute_angle),
    .second_angle(second_angle), .alarm_angle(alarm_angle), .alarm_en(alarm_en),
    .cordic_start(cordic_start), .cordic_angle(cordic_angle),
    .cordic_sin(cordic_sin), .cordic_cos(cordic_cos), .cordic_done(cordic_done),
    .clr_en(clr_en), .clr_row(clr_row), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int fl14(input int p);
    int v;
    v = p + 8192;
    if (v >= 0) return v / 16384;
    return -((-v + 16383) / 16384);
  endfunction

  function automatic int clampc(input int v);
    return (v < 0) ? 0 : ((v > 63) ? 63 : v);
  endfunction

  function automatic int pix(input int i);
    return (i < mon_wx.size()) ? mon_wx[i] * 64 + mon_wy[i] : -1;
  endfunction

  function automatic int rnd_q14(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // sin/cos unit: true trig values, or arbitrary full-range values to hit clamps
  initial begin
    int a, s, c, l;
    logic [15:0] t;
    real rad;
    cordic_done = 1'b0; cordic_sin = 16'd0; cordic_cos = 16'd0;
    forever begin
      @(posedge clk); #1;
      if (cordic_start === 1'b1) begin
        a = int'(cordic_angle);
        l = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
        if (rnd_cs) begin
          t = 16'($urandom); s = int'($signed(t));
          t = 16'($urandom); c = int'($signed(t));
        end else begin
          rad = real'(a) * 3.14159265358979323846 / 180.0;
          s = rnd_q14(16384.0 * $sin(rad));
          c = rnd_q14(16384.0 * $cos(rad));
        end
        rsp_sin.push_back(s); rsp_cos.push_back(c); rsp_lat.push_back(l);
        repeat (l) @(posedge clk);
        #1;
        cordic_done = 1'b1; cordic_sin = 16'(s); cordic_cos = 16'(c);
        @(posedge clk); #1;
        if (spurious) begin
          cordic_sin = 16'h7fff; cordic_cos = 16'h8000;
          @(posedge clk); #1;
        end
        cordic_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (clr_en === 1'b1) mon_clr.push_back(int'(clr_row));
      if (wr_en === 1'b1) begin
        mon_wx.push_back(int'(wr_x));
        mon_wy.push_back(int'(wr_y));
      end
      if (cordic_start === 1'b1) mon_req.push_back(int'(cordic_angle));
      if (done === 1'b1) mon_done++;
    end
  end

  task automatic clear_logs();
    mon_clr.delete(); mon_wx.delete(); mon_wy.delete(); mon_req.delete();
    rsp_sin.delete(); rsp_cos.delete(); rsp_lat.delete();
    mon_done = 0;
  endtask

  task automatic run_frame(input int h, input int m, input int s, input int a,
                           input bit en, input int lt, input bit rnd, input bit spur,
                           input bit inj, input bit sod);
    int angs[4], lens[4], ex[$], ey[$];
    int nh, n, exp_len, busy_low, bad;
    bit got;
    angs = '{h, m, s, a};
    lens = '{HL, ML, SL, AL};
    nh = en ? 4 : 3;
    clear_logs();
    lat = lt; rnd_cs = rnd; spurious = spur;
    hour_angle = 9'(h); minute_angle = 9'(m); second_angle = 9'(s); alarm_angle = 9'(a);
    alarm_en = en; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // later input changes must not leak into this frame
    hour_angle = 9'($urandom); minute_angle = 9'($urandom);
    second_angle = 9'($urandom); alarm_angle = 9'($urandom); alarm_en = ~en;
    n = 2; got = 0; busy_low = 0;
    for (int k = 0; k < 3000 && !got; k++) begin
      if (done === 1'b1) got = 1;
      else begin
        if (busy !== 1'b1) busy_low++;
        if (inj) start = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        n++;
      end
    end
    chk("done_seen", got, 1);
    chk("busy_held", busy_low, 0);
    chk("busy_at_done", busy, 0);
    exp_len = 1 + 64 + 1;
    for (int i = 0; i < nh; i++)
      exp_len += 1 + ((i < rsp_lat.size()) ? rsp_lat[i] : 0) + lens[i] + 1;
    chk("frame_len", n, exp_len);
    start = sod;
    @(posedge clk); #1;
    start = 1'b0;
    chk("idle_after_done", {busy, done, clr_en}, 0);
    @(posedge clk); #1;
    chk("no_restart", {busy, clr_en}, 0);
    chk("done_pulses", mon_done, 1);
    chk("clr_count", mon_clr.size(), 64);
    bad = 0;
    foreach (mon_clr[i]) if (mon_clr[i] != i) bad++;
    chk("clr_rows", bad, 0);
    chk("req_count", mon_req.size(), nh);
    for (int i = 0; i < nh && i < mon_req.size(); i++) chk("req_angle", mon_req[i], angs[i]);
    for (int i = 0; i < nh && i < rsp_sin.size(); i++)
      for (int r = 1; r <= lens[i]; r++) begin
        ex.push_back(clampc(32 + fl14(rsp_sin[i] * r)));
        ey.push_back(clampc(32 - fl14(rsp_cos[i] * r)));
      end
    chk("wr_count", mon_wx.size(), ex.size());
    for (int i = 0; i < ex.size() && i < mon_wx.size(); i++)
      chk($sformatf("px%0d", i), pix(i), ex[i] * 64 + ey[i]);
  endtask

  initial begin
    bit reached;
    reset = 1'b1; start = 1'b0; alarm_en = 1'b0;
    hour_angle = '0; minute_angle = '0; second_angle = '0; alarm_angle = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {cordic_start, clr_en, wr_en, busy, done}, 0);
    chk("rst_data", {cordic_angle, clr_row, wr_x, wr_y}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // all hands at 12, stray done pulses during PLOT, start on the done cycle
    run_frame(0, 0, 0, 0, 1, 1, 0, 1, 0, 1);
    chk("hour_first", pix(0), 32 * 64 + 31);
    chk("hour_last", pix(21), 32 * 64 + 10);
    chk("min_first", pix(22), 32 * 64 + 31);
    chk("min_last", pix(52), 32 * 64 + 1);
    chk("sec_last", pix(79), 32 * 64 + 5);
    chk("alarm_first", pix(80), 32 * 64 + 31);
    chk("alarm_last", pix(96), 32 * 64 + 15);

    // 45/90/180 degrees, alarm disabled
    run_frame(45, 90, 180, 300, 0, 2, 0, 0, 0, 0);
    chk("h45_first", pix(0), 33 * 64 + 31);
    chk("h45_last", pix(21), 48 * 64 + 16);
    chk("m90_first", pix(22), 33 * 64 + 32);
    chk("m90_last", pix(52), 63 * 64 + 32);
    chk("s180_first", pix(53), 32 * 64 + 33);
    chk("s180_last", pix(79), 32 * 64 + 59);

    // slow sin/cos unit with start hammered during the frame
    run_frame(int'($urandom_range(0, 359)), int'($urandom_range(0, 359)),
              int'($urandom_range(0, 359)), int'($urandom_range(0, 359)),
              1, 100, 1, 0, 1, 0);

    // random frames, angles beyond 359 included
    for (int f = 0; f < 5; f++)
      run_frame(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                1'($urandom), 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    // reset in the middle of the minute hand
    clear_logs();
    lat = 1; rnd_cs = 0; spurious = 0;
    hour_angle = 9'd30; minute_angle = 9'd200; second_angle = 9'd10; alarm_angle = 9'd0;
    alarm_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    reached = 0;
    for (int k = 0; k < 2000 && !reached; k++) begin
      @(posedge clk); #1;
      reached = (mon_req.size() >= 2) && (mon_wx.size() >= HL + 5);
    end
    chk("reached_min_plot", reached, 1);
    chk("in_plot", wr_en, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ctl", {cordic_start, clr_en, wr_en, busy, done}, 0);
    chk("mid_rst_data", {cordic_angle, clr_row, wr_x, wr_y}, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("no_done_after_rst", mon_done, 0);
    chk("idle_after_rst", {busy, clr_en, wr_en}, 0);

    run_frame(int'($urandom_range(0, 359)), int'($urandom_range(0, 359)),
              int'($urandom_range(0, 359)), int'($urandom_range(0, 359)),
              1, 1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
